// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  localparam int IMEM_WORDS = 32;
  localparam int ADDR_W     = 5;
  localparam int COUNT_W    = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus: control, byte stream, memory write port and status.
interface imem_loader_if #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W
);
  import imem_loader_pkg::*;

  logic               start;
  logic [COUNT_W-1:0] word_count;
  logic               byte_valid;
  logic [7:0]         byte_data;
  logic               byte_ready;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [31:0]        imem_wdata;
  logic               busy;
  logic               done;
  logic               cpu_reset;

  // Controller / byte source / memory side
  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, imem_we, imem_addr, imem_wdata, busy, done, cpu_reset
  );

  // Loader side
  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, imem_we, imem_addr, imem_wdata, busy, done, cpu_reset
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four big-endian bytes into one 32-bit instruction word.
module byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] cnt;

  // The byte being accepted now is the fourth one of the word.
  assign word_full = shift_en && (cnt == 2'd3);

  // Shift bytes in MSB-first; the counter wraps to 0 after the fourth byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift_en) begin
      cnt  <= cnt + 2'd1;
      word <= {word[23:0], byte_in};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program from a byte source into instruction memory while
// holding the CPU in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = imem_loader_pkg::IMEM_WORDS,
  parameter int ADDR_W     = imem_loader_pkg::ADDR_W
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

  state_t             state;
  logic [ADDR_W-1:0]  word_idx;
  logic [COUNT_W-1:0] count_q;
  logic               start_ok;
  logic               start_take;
  logic               last_word;
  logic               pk_clear;
  logic               pk_shift;
  logic               pk_full;
  logic [31:0]        pk_word;

  // A start is honoured only with a count in 1..IMEM_WORDS and only when idle or finished.
  assign start_ok   = bus.start && (bus.word_count != '0) &&
                      ({1'b0, bus.word_count} <= 7'(IMEM_WORDS));
  assign start_take = start_ok && ((state == IDLE) || (state == DONE));
  assign last_word  = (COUNT_W'(word_idx) + COUNT_W'(1)) == count_q;

  assign pk_shift = (state == LOAD) && bus.byte_valid;
  assign pk_clear = start_take || (state == WRITE);

  byte_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .clear    (pk_clear),
    .shift_en (pk_shift),
    .byte_in  (bus.byte_data),
    .word     (pk_word),
    .word_full(pk_full)
  );

  assign bus.byte_ready = (state == LOAD);
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = word_idx;
  assign bus.imem_wdata = pk_word;
  assign bus.busy       = (state == LOAD) || (state == WRITE);
  assign bus.done       = (state == DONE);
  assign bus.cpu_reset  = (state != DONE);

  // Load sequencing: wait for start, collect a word, write it, repeat until the count is met.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      word_idx <= '0;
      count_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            count_q  <= bus.word_count;
            word_idx <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          if (pk_full) state <= WRITE;
        end
        WRITE: begin
          if (last_word) begin
            state <= DONE;
          end else begin
            word_idx <= word_idx + 1'b1;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader.
module tb_imem_loader;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   wr_n;
  int   base;
  logic [4:0]  wr_addr [128];
  logic [31:0] wr_data [128];

  imem_loader_if #(.ADDR_W(5)) bus ();

  imem_loader #(.IMEM_WORDS(32), .ADDR_W(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (wr_n < 128) begin
        wr_addr[wr_n] = bus.imem_addr;
        wr_data[wr_n] = bus.imem_wdata;
      end
      wr_n = wr_n + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    bus.byte_data  = b;
    bus.byte_valid = 1'b1;
    n = 0;
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", {31'd0, bus.byte_ready}, 32'd1);
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start(input logic [5:0] wc);
    bus.word_count = wc;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    errors = 0;
    checks = 0;
    wr_n   = 0;
    bus.start      = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_busy",  {31'd0, bus.busy},       32'd0);
    check("rst_done",  {31'd0, bus.done},       32'd0);
    check("rst_we",    {31'd0, bus.imem_we},    32'd0);
    check("rst_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("rst_cpu",   {31'd0, bus.cpu_reset},  32'd1);
    reset = 1'b0;
    tick();
    check("idle_cpu", {31'd0, bus.cpu_reset}, 32'd1);

    // Illegal starts: count 0 and count 33
    do_start(6'd0);
    check("ill0_busy",  {31'd0, bus.busy},       32'd0);
    check("ill0_ready", {31'd0, bus.byte_ready}, 32'd0);
    do_start(6'd33);
    check("ill33_busy",  {31'd0, bus.busy},       32'd0);
    check("ill33_ready", {31'd0, bus.byte_ready}, 32'd0);
    tick();
    check("ill_done", {31'd0, bus.done}, 32'd0);
    check("ill_wr",   wr_n, 32'd0);

    // Single word
    do_start(6'd1);
    check("one_busy",  {31'd0, bus.busy},       32'd1);
    check("one_ready", {31'd0, bus.byte_ready}, 32'd1);
    send_word(32'h00622020);
    check("one_we",    {31'd0, bus.imem_we},    32'd1);
    check("one_addr",  {27'd0, bus.imem_addr},  32'd0);
    check("one_data",  bus.imem_wdata,          32'h00622020);
    check("one_wrdy",  {31'd0, bus.byte_ready}, 32'd0);
    tick();
    check("one_done",  {31'd0, bus.done},       32'd1);
    check("one_cpu",   {31'd0, bus.cpu_reset},  32'd0);
    check("one_we0",   {31'd0, bus.imem_we},    32'd0);
    check("one_drdy",  {31'd0, bus.byte_ready}, 32'd0);
    tick();
    check("one_sticky", {31'd0, bus.done}, 32'd1);

    // Reload from DONE: three words with a stall mid word 1
    base = wr_n;
    do_start(6'd3);
    check("rl_done", {31'd0, bus.done},      32'd0);
    check("rl_cpu",  {31'd0, bus.cpu_reset}, 32'd1);
    check("rl_busy", {31'd0, bus.busy},      32'd1);
    send_word(32'h8C450BB8);
    check("w0_addr", {27'd0, bus.imem_addr}, 32'd0);
    check("w0_data", bus.imem_wdata,         32'h8C450BB8);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hFF;
    tick();
    send_byte(8'h10);
    send_byte(8'h09);
    bus.byte_valid = 1'b0;
    bus.word_count = 6'd1;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("stall_wr",   wr_n - base, 32'd1);
    check("stall_busy", {31'd0, bus.busy}, 32'd1);
    send_byte(8'h00);
    send_byte(8'h0A);
    bus.byte_valid = 1'b0;
    check("w1_we",   {31'd0, bus.imem_we},   32'd1);
    check("w1_addr", {27'd0, bus.imem_addr}, 32'd1);
    check("w1_data", bus.imem_wdata,         32'h1009000A);
    tick();
    check("w1_done", {31'd0, bus.done}, 32'd0);
    send_word(32'h01A00008);
    check("w2_addr", {27'd0, bus.imem_addr}, 32'd2);
    check("w2_data", bus.imem_wdata,         32'h01A00008);
    tick();
    check("three_done", {31'd0, bus.done}, 32'd1);
    check("three_wr",   wr_n - base,       32'd3);

    // Full memory
    base = wr_n;
    do_start(6'd32);
    for (int i = 0; i < 32; i++) begin
      w = {i[7:0], 8'hA5, 8'h5A, ~i[7:0]};
      send_word(w);
      check("full_addr", {27'd0, bus.imem_addr}, i);
      check("full_data", bus.imem_wdata,         w);
      tick();
    end
    check("full_done", {31'd0, bus.done}, 32'd1);
    check("full_wr",   wr_n - base,       32'd32);
    check("full_last", {27'd0, wr_addr[base+31]}, 32'd31);

    // Reset mid-load
    do_start(6'd3);
    send_word(32'hAABBCCDD);
    tick();
    send_word(32'h11223344);
    tick();
    send_byte(8'h55);
    send_byte(8'h66);
    bus.byte_valid = 1'b0;
    base  = wr_n;
    reset = 1'b1;
    tick();
    check("ab_busy",  {31'd0, bus.busy},       32'd0);
    check("ab_ready", {31'd0, bus.byte_ready}, 32'd0);
    check("ab_cpu",   {31'd0, bus.cpu_reset},  32'd1);
    check("ab_done",  {31'd0, bus.done},       32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("ab_nowr", wr_n - base, 32'd0);
    do_start(6'd1);
    send_word(32'h12345678);
    check("ab_we",   {31'd0, bus.imem_we},   32'd1);
    check("ab_addr", {27'd0, bus.imem_addr}, 32'd0);
    check("ab_data", bus.imem_wdata,         32'h12345678);
    tick();
    check("ab_fin", {31'd0, bus.done}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
